mips_mem_arbiter: RTL and testbench

- Sequences a single-port unified memory shared by the pipeline's instruction-fetch (IF) port and data-access (MEM) port.
- Arbitrates between the two ports, issues one memory access at a time, and waits a fixed memory latency.
- Returns read data with a one-cycle ack pulse and drives stall signals back to the pipeline.
- Data port has priority; an anti-starvation counter guarantees fetch progress.

---
 rtl/mips_mem_arbiter.sv | 112 +++++++++++
 tb/tb_mips_mem_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mem_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
// The data port has priority; a starvation counter forces a fetch grant after STARVE_LIMIT data wins.
module mips_mem_arbiter #(
  parameter int unsigned AW           = 10,
  parameter int unsigned DW           = 32,
  parameter int unsigned MEM_LAT      = 1,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  output logic          if_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          d_stall,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StAck} state_e;

  localparam logic [3:0] LatInit   = 4'(MEM_LAT);
  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

  state_e     state;
  logic       owner_d;  // 1: data port owns the current access
  logic [3:0] lat_cnt;
  logic [3:0] starve_cnt;
  logic       if_wins;

  assign if_wins  = if_req & (~d_req | (starve_cnt == StarveMax));
  assign if_stall = if_req & ~if_ack;
  assign d_stall  = d_req & ~d_ack;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= StIdle;
      owner_d    <= 1'b0;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_ack     <= 1'b0;
      d_ack      <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      busy       <= 1'b0;
    end else begin
      mem_en <= 1'b0;
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      unique case (state)
        StIdle: begin
          if (if_req || d_req) begin
            if (if_wins) begin
              owner_d    <= 1'b0;
              mem_addr   <= if_addr;
              mem_we     <= 1'b0;
              mem_wdata  <= '0;
              starve_cnt <= '0;
            end else begin
              owner_d   <= 1'b1;
              mem_addr  <= d_addr;
              mem_we    <= d_we;
              mem_wdata <= d_wdata;
              if (if_req && starve_cnt < StarveMax) starve_cnt <= starve_cnt + 4'd1;
            end
            mem_en <= 1'b1;
            busy   <= 1'b1;
            state  <= StIssue;
          end
        end
        StIssue: begin
          lat_cnt <= LatInit;
          state   <= StWait;
        end
        StWait: begin
          lat_cnt <= lat_cnt - 4'd1;
          if (lat_cnt == 4'd1) begin
            if (owner_d) begin
              d_ack <= 1'b1;
              if (!mem_we) d_rdata <= mem_rdata;
            end else begin
              if_ack   <= 1'b1;
              if_rdata <= mem_rdata;
            end
            state <= StAck;
          end
        end
        StAck: begin
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Bench for mips_mem_arbiter: instance 0 runs MEM_LAT=1, instance 1 runs MEM_LAT=4.
module tb_mips_mem_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]    rst, if_req, if_ack, if_stall, d_req, d_we, d_ack, d_stall, mem_en, mem_we, busy;
  logic [AW-1:0] if_addr [2];
  logic [AW-1:0] d_addr [2];
  logic [AW-1:0] mem_addr [2];
  logic [DW-1:0] if_rdata [2];
  logic [DW-1:0] d_wdata [2];
  logic [DW-1:0] d_rdata [2];
  logic [DW-1:0] mem_wdata [2];
  logic [DW-1:0] mem_rdata [2];

  mips_mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1), .STARVE_LIMIT(3)) u_dut0 (
    .clk(clk), .reset(rst[0]),
    .if_req(if_req[0]), .if_addr(if_addr[0]), .if_ack(if_ack[0]), .if_rdata(if_rdata[0]),
    .if_stall(if_stall[0]), .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]),
    .d_wdata(d_wdata[0]), .d_ack(d_ack[0]), .d_rdata(d_rdata[0]), .d_stall(d_stall[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0]), .busy(busy[0])
  );

  mips_mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(4), .STARVE_LIMIT(3)) u_dut1 (
    .clk(clk), .reset(rst[1]),
    .if_req(if_req[1]), .if_addr(if_addr[1]), .if_ack(if_ack[1]), .if_rdata(if_rdata[1]),
    .if_stall(if_stall[1]), .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]),
    .d_wdata(d_wdata[1]), .d_ack(d_ack[1]), .d_rdata(d_rdata[1]), .d_stall(d_stall[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1]), .busy(busy[1])
  );

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  // Memory model: read data is driven only in the cycle exactly LAT cycles after the strobe.
  logic [DW-1:0] mem [2][0:1023];
  logic [DW-1:0] rbuf [2];
  int            cyc = 0;
  int            vcyc [2] = '{-1, -1};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cyc == 0) begin
      mem[0][4] <= 32'h2002_0014;
      mem[1][4] <= 32'h2002_0014;
    end
    for (int k = 0; k < 2; k++) begin
      if (mem_en[k]) begin
        if (mem_we[k]) mem[k][mem_addr[k]] <= mem_wdata[k];
        else begin
          rbuf[k] <= mem[k][mem_addr[k]];
          vcyc[k] <= cyc + lat_of(k);
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      mem_rdata[k] = (cyc == vcyc[k]) ? rbuf[k] : 32'hDEAD_BEEF;
    end
  end

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request, waits for its ack, and reports what was seen on the memory side.
  task automatic access(input int k, input bit isd, input bit we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, output int n, output int busy_n,
                        output int strobes, output logic sw, output logic [AW-1:0] sa,
                        output logic [DW-1:0] rd);
    logic stall_at_ack;
    if (isd) begin
      d_req[k] = 1'b1; d_we[k] = we; d_addr[k] = addr; d_wdata[k] = wd;
    end else begin
      if_req[k] = 1'b1; if_addr[k] = addr;
    end
    n = 40; busy_n = 0; strobes = 0; sw = 1'b0; sa = '0; stall_at_ack = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (busy[k]) busy_n++;
      if (mem_en[k]) begin
        strobes++;
        sw = mem_we[k];
        sa = mem_addr[k];
      end
      if (isd ? d_ack[k] : if_ack[k]) begin
        n = i;
        stall_at_ack = isd ? d_stall[k] : if_stall[k];
        break;
      end
    end
    check("stall_in_ack_cycle", {31'd0, stall_at_ack}, 32'd0);
    rd = isd ? d_rdata[k] : if_rdata[k];
    if (isd) d_req[k] = 1'b0;
    else if_req[k] = 1'b0;
  endtask

  typedef struct {
    int            k;
    bit            isd;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic [DW-1:0] exp_rd;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int n, busy_n, strobes;
    logic sw;
    logic [AW-1:0] sa;
    logic [DW-1:0] rd;
    logic [7:0] order;
    int g, both, ack_t [3], na;
    logic seen_if, seen_d;

    vecs[0] = '{0, 1'b0, 1'b0, 10'h004, 32'h0, 32'h2002_0014};
    vecs[1] = '{0, 1'b1, 1'b1, 10'h010, 32'h0000_002D, 32'h0};
    vecs[2] = '{0, 1'b1, 1'b0, 10'h010, 32'h0, 32'h0000_002D};
    vecs[3] = '{0, 1'b1, 1'b1, 10'h010, 32'h0000_0055, 32'h0000_002D};
    vecs[4] = '{0, 1'b0, 1'b0, 10'h010, 32'h0, 32'h0000_0055};
    vecs[5] = '{1, 1'b0, 1'b0, 10'h004, 32'h0, 32'h2002_0014};
    vecs[6] = '{1, 1'b1, 1'b1, 10'h020, 32'h0000_CAFE, 32'h0};
    vecs[7] = '{1, 1'b1, 1'b0, 10'h020, 32'h0, 32'h0000_CAFE};

    rst = 2'b11; if_req = '0; d_req = '0; d_we = '0;
    for (int k = 0; k < 2; k++) begin
      if_addr[k] = '0; d_addr[k] = '0; d_wdata[k] = '0;
    end
    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin
      check("reset_busy", {31'd0, busy[k]}, 32'd0);
      check("reset_mem_en", {31'd0, mem_en[k]}, 32'd0);
      check("reset_acks", {30'd0, if_ack[k], d_ack[k]}, 32'd0);
      check("reset_rdata", if_rdata[k] | d_rdata[k], 32'd0);
      check("reset_mem_addr", {22'd0, mem_addr[k]}, 32'd0);
    end
    rst = 2'b00;
    tick();

    for (int v = 0; v < 8; v++) begin
      access(vecs[v].k, vecs[v].isd, vecs[v].we, vecs[v].addr, vecs[v].wd,
             n, busy_n, strobes, sw, sa, rd);
      check($sformatf("v%0d_latency", v), n, lat_of(vecs[v].k) + 2);
      check($sformatf("v%0d_busy_cycles", v), busy_n, lat_of(vecs[v].k) + 2);
      check($sformatf("v%0d_strobes", v), strobes, 1);
      check($sformatf("v%0d_mem_we", v), {31'd0, sw}, {31'd0, vecs[v].we});
      check($sformatf("v%0d_mem_addr", v), {22'd0, sa}, {22'd0, vecs[v].addr});
      check($sformatf("v%0d_rdata", v), rd, vecs[v].exp_rd);
      tick();
      check($sformatf("v%0d_idle_after", v), {31'd0, busy[vecs[v].k]}, 32'd0);
      check($sformatf("v%0d_rdata_held", v),
            vecs[v].isd ? d_rdata[vecs[v].k] : if_rdata[vecs[v].k], vecs[v].exp_rd);
    end

    // Both ports held on instance 0: three data grants, then a forced fetch grant.
    if_addr[0] = 10'h004; d_addr[0] = 10'h010; d_we[0] = 1'b0;
    if_req[0] = 1'b1; d_req[0] = 1'b1;
    order = '0; g = 0; both = 0;
    for (int i = 0; i < 100 && g < 8; i++) begin
      tick();
      if (if_ack[0] && d_ack[0]) both++;
      if (if_ack[0] || d_ack[0]) begin
        order[g] = if_ack[0];
        g++;
      end
    end
    if_req[0] = 1'b0; d_req[0] = 1'b0;
    check("starve_grant_count", g, 8);
    check("starve_order", {24'd0, order}, 32'h88);
    check("starve_no_double_ack", both, 0);
    tick();

    // Back-to-back fetches on instance 1 (MEM_LAT=4) are 7 cycles apart.
    if_addr[1] = 10'h004; if_req[1] = 1'b1;
    na = 0;
    for (int i = 0; i < 60 && na < 3; i++) begin
      tick();
      if (if_ack[1]) begin
        ack_t[na] = i;
        na++;
      end
    end
    if_req[1] = 1'b0;
    check("b2b_ack_count", na, 3);
    check("b2b_spacing_1", ack_t[1] - ack_t[0], 7);
    check("b2b_spacing_2", ack_t[2] - ack_t[1], 7);
    tick();

    // Reset while a data read is in WAIT on instance 1.
    check("pre_reset_d_rdata", d_rdata[1], 32'h0000_CAFE);
    d_we[1] = 1'b0; d_addr[1] = 10'h020; d_req[1] = 1'b1;
    repeat (3) tick();
    check("mid_wait_busy", {31'd0, busy[1]}, 32'd1);
    rst[1] = 1'b1; d_req[1] = 1'b0;
    tick();
    check("rst_mid_busy", {31'd0, busy[1]}, 32'd0);
    check("rst_mid_d_ack", {31'd0, d_ack[1]}, 32'd0);
    check("rst_mid_d_rdata", d_rdata[1], 32'd0);
    check("rst_mid_mem_en", {31'd0, mem_en[1]}, 32'd0);
    rst[1] = 1'b0;
    seen_d = 1'b0;
    repeat (8) begin
      tick();
      seen_d |= d_ack[1];
    end
    check("rst_mid_no_late_ack", {31'd0, seen_d}, 32'd0);
    access(1, 1'b0, 1'b0, 10'h004, 32'h0, n, busy_n, strobes, sw, sa, rd);
    check("post_reset_if_latency", n, 6);
    check("post_reset_if_rdata", rd, 32'h2002_0014);
    tick();

    // Data request raised and dropped while a fetch is in flight: no data ack.
    if_addr[1] = 10'h004; if_req[1] = 1'b1;
    tick();
    d_we[1] = 1'b0; d_addr[1] = 10'h020; d_req[1] = 1'b1;
    tick();
    tick();
    d_req[1] = 1'b0;
    seen_if = 1'b0; seen_d = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      seen_d |= d_ack[1];
      if (if_ack[1]) begin
        seen_if = 1'b1;
        if_req[1] = 1'b0;
      end
    end
    if_req[1] = 1'b0;
    check("drop_if_completed", {31'd0, seen_if}, 32'd1);
    check("drop_no_d_ack", {31'd0, seen_d}, 32'd0);
    check("drop_idle_busy", {31'd0, busy[1]}, 32'd0);
    check("drop_if_rdata", if_rdata[1], 32'h2002_0014);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
